interrupt_controller: RTL and testbench

Collects event sources (internal periodic timer, keyboard strobe, GPU-ready edge) and presents them one at a time to the game processor. The processor sees them through a 2-bit encoded IRQ with an IACK/IEND handshake. It sits directly upstream of the game processor's INT_IRQ/INT_IACK/INT_IEND ports. Requests are latched as pending, arbitrated by fixed priority, and dispatched strictly one at a time.

---
 rtl/interrupt_controller.sv | 132 +++++++++++++
 tb/tb_interrupt_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches timer / keyboard / GPU events as pending,
// picks one by fixed priority (timer > keyboard > GPU) and hands it to the
// game processor through a 2-bit IRQ code with an IACK/IEND handshake.
module interrupt_controller #(
  parameter int unsigned         TIMER_W      = 16,
  parameter logic [TIMER_W-1:0]  TIMER_PERIOD = 16'd50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TIMER_EN,
  input  logic       KBD_STROBE,
  input  logic       GPU_READY,
  input  logic       INT_ENABLE,
  output logic [1:0] INT_IRQ,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  output logic       IN_SERVICE,
  output logic [2:0] PENDING,
  output logic [2:0] LOST,
  input  logic       LOST_CLR
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

  localparam logic [TIMER_W-1:0] TMAX = TIMER_PERIOD - TIMER_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         cur_id_q, cur_id_d;
  logic [1:0]         irq_q, irq_d;
  logic               insvc_q, insvc_d;
  logic [2:0]         pend_q, pend_d;
  logic [2:0]         lost_q, lost_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               kbd_prev_q, gpu_prev_q;
  logic [2:0]         evt;
  logic [2:0]         clr;

  // Event detection: rising edges of the two levels, plus the timer wrap.
  // The timer holds (and stays silent) while disabled.
  always_comb begin
    evt   = {GPU_READY & ~gpu_prev_q, KBD_STROBE & ~kbd_prev_q,
             TIMER_EN & (cnt_q == TMAX)};
    cnt_d = cnt_q;
    if (TIMER_EN) cnt_d = (cnt_q == TMAX) ? '0 : cnt_q + TIMER_W'(1);
  end

  // Dispatch FSM: selection uses registered PENDING; a request, once raised,
  // is neither withdrawn nor pre-empted until IACK.
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    irq_d    = irq_q;
    insvc_d  = insvc_q;
    clr      = 3'b000;
    case (state_q)
      S_IDLE: begin
        irq_d   = 2'b00;
        insvc_d = 1'b0;
        if (INT_ENABLE && pend_q != 3'b000) begin
          if (pend_q[0])      cur_id_d = 2'd1;
          else if (pend_q[1]) cur_id_d = 2'd2;
          else                cur_id_d = 2'd3;
          irq_d   = cur_id_d;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // IEND arriving alongside IACK is simply not looked at here.
        if (INT_IACK) begin
          case (cur_id_q)
            2'd1:    clr = 3'b001;
            2'd2:    clr = 3'b010;
            2'd3:    clr = 3'b100;
            default: clr = 3'b000;
          endcase
          irq_d   = 2'b00;
          insvc_d = 1'b1;
          state_d = S_SVC;
        end
      end
      S_SVC: begin
        if (INT_IEND) begin
          insvc_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        irq_d   = 2'b00;
        insvc_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pending/lost bookkeeping: a new event always beats a clear, and an
  // overflow only counts if the bit is not being cleared this cycle.
  always_comb begin
    pend_d = (pend_q & ~clr) | evt;
    lost_d = (LOST_CLR ? 3'b000 : lost_q) | (evt & pend_q & ~clr);
  end

  // State registers; reset abandons any in-flight handshake.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cur_id_q   <= 2'b00;
      irq_q      <= 2'b00;
      insvc_q    <= 1'b0;
      pend_q     <= 3'b000;
      lost_q     <= 3'b000;
      cnt_q      <= '0;
      kbd_prev_q <= 1'b0;
      gpu_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      irq_q      <= irq_d;
      insvc_q    <= insvc_d;
      pend_q     <= pend_d;
      lost_q     <= lost_d;
      cnt_q      <= cnt_d;
      kbd_prev_q <= KBD_STROBE;
      gpu_prev_q <= GPU_READY;
    end
  end

  assign INT_IRQ    = irq_q;
  assign IN_SERVICE = insvc_q;
  assign PENDING    = pend_q;
  assign LOST       = lost_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios with hand-derived
// expectations plus a randomized run against a cycle-level reference model.
module tb_interrupt_controller;

  localparam int PER    = 8;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SVC  = 2;

  logic       CLK = 1'b0;
  logic       RESET, TIMER_EN, KBD_STROBE, GPU_READY, INT_ENABLE;
  logic       INT_IACK, INT_IEND, LOST_CLR;
  logic [1:0] INT_IRQ;
  logic       IN_SERVICE;
  logic [2:0] PENDING, LOST;
  logic [8:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // reference model state
  int       m_cnt;
  bit       m_kprev, m_gprev;
  bit [2:0] m_pend, m_lost;
  int       m_phase;
  int       m_id;

  interrupt_controller #(.TIMER_W(16), .TIMER_PERIOD(16'd8)) dut (
    .CLK(CLK), .RESET(RESET), .TIMER_EN(TIMER_EN), .KBD_STROBE(KBD_STROBE),
    .GPU_READY(GPU_READY), .INT_ENABLE(INT_ENABLE), .INT_IRQ(INT_IRQ),
    .INT_IACK(INT_IACK), .INT_IEND(INT_IEND), .IN_SERVICE(IN_SERVICE),
    .PENDING(PENDING), .LOST(LOST), .LOST_CLR(LOST_CLR)
  );

  always #5 CLK = ~CLK;

  assign dut_vec = {INT_IRQ, IN_SERVICE, PENDING, LOST};

  task automatic model_reset();
    m_cnt = 0; m_kprev = 0; m_gprev = 0;
    m_pend = 3'b000; m_lost = 3'b000; m_phase = P_IDLE; m_id = 0;
  endtask

  // One rising edge of the reference, using the inputs currently applied.
  task automatic model_edge();
    bit [2:0] ev, clr, nxt;
    ev[0] = TIMER_EN && (m_cnt == PER - 1);
    ev[1] = KBD_STROBE && !m_kprev;
    ev[2] = GPU_READY && !m_gprev;
    clr = 3'b000;
    if (m_phase == P_REQ && INT_IACK) clr[m_id - 1] = 1'b1;
    m_lost = (LOST_CLR ? 3'b000 : m_lost) | (ev & m_pend & ~clr);
    nxt = (m_pend & ~clr) | ev;
    if (m_phase == P_IDLE) begin
      if (INT_ENABLE && m_pend != 3'b000) begin
        for (int i = 2; i >= 0; i--) if (m_pend[i]) m_id = i + 1;
        m_phase = P_REQ;
      end
    end else if (m_phase == P_REQ) begin
      if (INT_IACK) m_phase = P_SVC;
    end else begin
      if (INT_IEND) m_phase = P_IDLE;
    end
    m_pend = nxt;
    if (TIMER_EN) m_cnt = (m_cnt + 1) % PER;
    m_kprev = KBD_STROBE;
    m_gprev = GPU_READY;
  endtask

  function automatic logic [8:0] exp_vec();
    logic [1:0] irq;
    irq = (m_phase == P_REQ) ? 2'(m_id) : 2'b00;
    return {irq, m_phase == P_SVC, m_pend, m_lost};
  endfunction

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    RESET = 1; TIMER_EN = 0; KBD_STROBE = 0; GPU_READY = 0; INT_ENABLE = 0;
    INT_IACK = 0; INT_IEND = 0; LOST_CLR = 0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec !== 9'b0) begin
      errors++; $display("FAIL reset_state: got %b exp %b", dut_vec, 9'b0);
    end
  endtask

  // Timer ticks at edge 8, IRQ one edge later and held; second tick overflows.
  task automatic test_timer();
    TIMER_EN = 1; INT_ENABLE = 1;
    for (int c = 1; c <= 17; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL timer_model c%0d: got %b exp %b", c, dut_vec, exp_vec());
      end
      if (c == 7) begin
        checks++;
        if (PENDING !== 3'b000) begin
          errors++; $display("FAIL timer_early: got %b exp 000", PENDING);
        end
      end
      if (c == 8) begin
        checks++;
        if ({INT_IRQ, PENDING} !== 5'b00_001) begin
          errors++; $display("FAIL timer_tick: got %b exp 00001", {INT_IRQ, PENDING});
        end
      end
      if (c == 9 || c == 15) begin
        checks++;
        if (INT_IRQ !== 2'b01) begin
          errors++; $display("FAIL timer_irq c%0d: got %b exp 01", c, INT_IRQ);
        end
      end
      if (c == 16) begin
        checks++;
        if ({INT_IRQ, LOST} !== 5'b01_001) begin
          errors++; $display("FAIL timer_lost: got %b exp 01001", {INT_IRQ, LOST});
        end
      end
    end
    TIMER_EN = 0;
  endtask

  // Keyboard and GPU together: keyboard first, GPU after IEND + idle cycle.
  task automatic test_two_events();
    apply_reset();
    INT_ENABLE = 1; KBD_STROBE = 1; GPU_READY = 1;
    step(); step();
    checks++;
    if ({INT_IRQ, PENDING} !== 5'b10_110) begin
      errors++; $display("FAIL two_req: got %b exp 10110", {INT_IRQ, PENDING});
    end
    INT_IACK = 1; step(); INT_IACK = 0;
    checks++;
    if ({INT_IRQ, IN_SERVICE, PENDING} !== 6'b00_1_100) begin
      errors++; $display("FAIL two_iack: got %b exp 001100", {INT_IRQ, IN_SERVICE, PENDING});
    end
    INT_IEND = 1; step(); INT_IEND = 0;
    checks++;
    if ({INT_IRQ, IN_SERVICE} !== 3'b00_0) begin
      errors++; $display("FAIL two_gap: got %b exp 000", {INT_IRQ, IN_SERVICE});
    end
    step();
    checks++;
    if (INT_IRQ !== 2'b11) begin
      errors++; $display("FAIL two_gpu: got %b exp 11", INT_IRQ);
    end
  endtask

  // A timer tick during the GPU request must not pre-empt it.
  task automatic test_no_preempt();
    TIMER_EN = 1;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (INT_IRQ !== 2'b11) begin
        errors++; $display("FAIL preempt c%0d: got %b exp 11", c, INT_IRQ);
      end
    end
    TIMER_EN = 0;
    checks++;
    if (PENDING !== 3'b101) begin
      errors++; $display("FAIL preempt_pend: got %b exp 101", PENDING);
    end
    INT_IACK = 1; step(); INT_IACK = 0;
    INT_IEND = 1; step(); INT_IEND = 0;
    checks++;
    if (INT_IRQ !== 2'b00) begin
      errors++; $display("FAIL preempt_gap: got %b exp 00", INT_IRQ);
    end
    step();
    checks++;
    if (INT_IRQ !== 2'b01) begin
      errors++; $display("FAIL preempt_timer: got %b exp 01", INT_IRQ);
    end
  endtask

  // Global enable gating and ignored handshake pulses.
  task automatic test_enable_gate();
    apply_reset();
    KBD_STROBE = 1; GPU_READY = 1;
    step(); step(); step();
    INT_IACK = 1; step(); INT_IACK = 0;
    checks++;
    if ({INT_IRQ, IN_SERVICE, PENDING} !== 6'b00_0_110) begin
      errors++; $display("FAIL gate_off: got %b exp 000110", {INT_IRQ, IN_SERVICE, PENDING});
    end
    INT_ENABLE = 1; step();
    checks++;
    if (INT_IRQ !== 2'b10) begin
      errors++; $display("FAIL gate_on: got %b exp 10", INT_IRQ);
    end
    INT_IEND = 1; step(); INT_IEND = 0;
    checks++;
    if ({INT_IRQ, IN_SERVICE, PENDING} !== 6'b10_0_110) begin
      errors++; $display("FAIL stray_iend: got %b exp 100110", {INT_IRQ, IN_SERVICE, PENDING});
    end
    INT_IACK = 1; INT_IEND = 1; step(); INT_IACK = 0; INT_IEND = 0;
    checks++;
    if ({INT_IRQ, IN_SERVICE, PENDING} !== 6'b00_1_100) begin
      errors++; $display("FAIL iack_iend: got %b exp 001100", {INT_IRQ, IN_SERVICE, PENDING});
    end
  endtask

  // Asynchronous reset mid-service, then the timer restarts from zero.
  task automatic test_async_reset();
    TIMER_EN = 1;
    step(); step(); step();
    #2 RESET = 1; KBD_STROBE = 0; GPU_READY = 0;
    #1;
    checks++;
    if (dut_vec !== 9'b0) begin
      errors++; $display("FAIL async_reset: got %b exp %b", dut_vec, 9'b0);
    end
    model_reset();
    @(negedge CLK);
    RESET = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL restart_model c%0d: got %b exp %b", c, dut_vec, exp_vec());
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (PENDING !== ((c == 8) ? 3'b001 : 3'b000)) begin
          errors++; $display("FAIL restart_tick c%0d: got %b", c, PENDING);
        end
      end
    end
    TIMER_EN = 0;
  endtask

  // Same-cycle set vs clear, and LOST_CLR vs a fresh overflow.
  task automatic test_same_cycle();
    apply_reset();
    INT_ENABLE = 1; KBD_STROBE = 1;
    step(); step();
    KBD_STROBE = 0; step();
    KBD_STROBE = 1; INT_IACK = 1; step(); INT_IACK = 0;
    checks++;
    if ({IN_SERVICE, PENDING, LOST} !== 7'b1_010_000) begin
      errors++; $display("FAIL set_vs_clr: got %b exp 1010000", {IN_SERVICE, PENDING, LOST});
    end
    GPU_READY = 1; step();
    GPU_READY = 0; step();
    GPU_READY = 1; LOST_CLR = 1; step();
    checks++;
    if ({PENDING, LOST} !== 6'b110_100) begin
      errors++; $display("FAIL clr_vs_lost: got %b exp 110100", {PENDING, LOST});
    end
    GPU_READY = 0; step(); LOST_CLR = 0;
    checks++;
    if (LOST !== 3'b000) begin
      errors++; $display("FAIL lost_clr: got %b exp 000", LOST);
    end
  endtask

  // Random traffic against the reference model, every cycle.
  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      TIMER_EN   = ($urandom_range(0, 3) != 0);
      KBD_STROBE = ($urandom_range(0, 2) == 0);
      GPU_READY  = ($urandom_range(0, 2) == 0);
      INT_ENABLE = ($urandom_range(0, 7) != 0);
      INT_IACK   = ($urandom_range(0, 3) == 0);
      INT_IEND   = ($urandom_range(0, 3) == 0);
      LOST_CLR   = ($urandom_range(0, 15) == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random c%0d: got %b exp %b", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    RESET = 1; TIMER_EN = 0; KBD_STROBE = 0; GPU_READY = 0; INT_ENABLE = 0;
    INT_IACK = 0; INT_IEND = 0; LOST_CLR = 0;
    model_reset();
    test_reset();
    test_timer();
    test_two_events();
    test_no_preempt();
    test_enable_gate();
    test_async_reset();
    test_same_cycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
